// File: rtl/ball_if.sv
// ball_if: bundle between the ball engine and the map and display side.
//   q_lane, q_row : map tile query, driven by the ball engine
//   tile_solid    : map answer for (q_lane, q_row), valid 1 clk after the query changes
//   x_ball, y_ball, ball_state, fail : game state consumed by the display
// master = ball engine, slave = map/display side.
interface ball_if;
   logic [2:0]  q_lane;
   logic [10:0] q_row;
   logic        tile_solid;
   logic [9:0]  x_ball;
   logic [25:0] y_ball;
   logic [2:0]  ball_state;
   logic        fail;

   modport master (
      output q_lane, q_row, x_ball, y_ball, ball_state, fail,
      input  tile_solid
   );

   modport slave (
      input  q_lane, q_row, x_ball, y_ball, ball_state, fail,
      output tile_solid
   );
endinterface

// File: rtl/ball_ctrl.sv
// ball_ctrl: game-state engine feeding the VGA renderer.
// The ball moves forward by SPEED on every frame tick and is steered by the buttons.
// The jump button starts a run or triggers a jump. The engine detects a fall when
// the map tile under a grounded ball is not solid.
// Ports:
//   clk, clrn                          clock, asynchronous active-low reset
//   tick                               one-cycle frame strobe
//   btn_left, btn_right, btn_jump      raw asynchronous buttons
//   bus (ball_if.master)               map query and ball outputs
module ball_ctrl #(
   parameter int SPEED       = 4,
   parameter int XSPEED      = 3,
   parameter int X_MIN       = 46,
   parameter int X_MAX       = 353,
   parameter int X_INIT      = 200,
   parameter int ROW_LEN     = 80,
   parameter int LANE_W      = 50,
   parameter int STEP_FRAMES = 4,
   parameter int WIN_Y       = 16000
) (
   input  logic   clk,
   input  logic   clrn,
   input  logic   tick,
   input  logic   btn_left,
   input  logic   btn_right,
   input  logic   btn_jump,
   ball_if.master bus
);

   typedef enum logic [2:0] {IDLE, RUN, AIR, DEAD, WON} state_t;

   localparam int REM_W = $clog2(ROW_LEN + SPEED) + 1;
   localparam int CNT_W = $clog2(STEP_FRAMES) + 1;

   localparam logic [10:0]      X_MIN_W   = 11'(X_MIN);
   localparam logic [10:0]      X_MAX_W   = 11'(X_MAX);
   localparam logic [10:0]      XSPEED_W  = 11'(XSPEED);
   localparam logic [25:0]      SPEED_Y   = 26'(SPEED);
   localparam logic [25:0]      WIN_Y_W   = 26'(WIN_Y);
   localparam logic [REM_W-1:0] SPEED_R   = REM_W'(SPEED);
   localparam logic [REM_W-1:0] ROW_LEN_R = REM_W'(ROW_LEN);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);

   state_t           state_reg, state_next;
   logic [9:0]       x_reg, x_next;
   logic [25:0]      y_reg, y_next;
   logic [REM_W-1:0] rem_reg, rem_next;
   logic [10:0]      row_reg, row_next;
   logic [2:0]       lane_reg, lane_next;
   logic [2:0]       bs_reg, bs_next;
   logic [3:0]       phase_reg, phase_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             fail_reg, fail_next;
   logic             jump_req_reg, jump_req_next;
   logic             tick_d1_reg, tick_d2_reg;

   logic left_s1_reg, left_s2_reg, right_s1_reg, right_s2_reg;
   logic jump_s1_reg, jump_s2_reg, jump_s3_reg;
   logic jump_pulse, jump_seen;

   // Jump arc: phases 0..9 map to heights 1,2,3,4,5,5,4,3,2,1.
   function automatic logic [2:0] height_of(input logic [3:0] p);
      logic [3:0] h;
      h = (p < 4'd5) ? p + 4'd1 : 4'd10 - p;
      return h[2:0];
   endfunction

   assign jump_pulse = jump_s2_reg & ~jump_s3_reg;
   // A pulse on the tick cycle itself still counts for that tick.
   assign jump_seen  = jump_req_reg | jump_pulse;

   // Lane lookup without a divider: lane = number of lane boundaries at or left of x.
   logic [6:0] lane_ge;
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_lane
         assign lane_ge[gi] = (x_reg >= 10'((gi + 1) * LANE_W));
      end
   endgenerate

   always_comb begin
      lane_next = 3'd0;
      for (int i = 0; i < 7; i++) begin
         lane_next = lane_next + {2'b00, lane_ge[i]};
      end
   end

   // Saturating steering, computed one bit wider so that nothing wraps.
   logic [10:0] x_wide, x_left, x_right, x_steer;
   always_comb begin
      x_wide  = {1'b0, x_reg};
      x_left  = (x_wide < X_MIN_W + XSPEED_W) ? X_MIN_W : x_wide - XSPEED_W;
      x_right = (x_wide + XSPEED_W > X_MAX_W) ? X_MAX_W : x_wide + XSPEED_W;
      x_steer = x_wide;
      if (left_s2_reg && !right_s2_reg) x_steer = x_left;
      if (right_s2_reg && !left_s2_reg) x_steer = x_right;
   end

   logic [25:0]      y_adv;
   logic [REM_W-1:0] rem_sum;
   assign y_adv   = y_reg + SPEED_Y;
   assign rem_sum = rem_reg + SPEED_R;

   always_comb begin
      state_next    = state_reg;
      x_next        = x_reg;
      y_next        = y_reg;
      rem_next      = rem_reg;
      row_next      = row_reg;
      bs_next       = bs_reg;
      phase_next    = phase_reg;
      cnt_next      = cnt_reg;
      fail_next     = fail_reg;
      jump_req_next = jump_req_reg;

      if (tick)            jump_req_next = 1'b0;
      else if (jump_pulse) jump_req_next = 1'b1;

      if (tick) begin
         case (state_reg)
            IDLE: if (jump_seen) state_next = RUN;
            RUN, AIR: begin
               y_next = y_adv;
               x_next = x_steer[9:0];
               // Row counter tracks y_ball / ROW_LEN incrementally.
               if (rem_sum >= ROW_LEN_R) begin
                  rem_next = rem_sum - ROW_LEN_R;
                  if (row_reg != 11'h7FF) row_next = row_reg + 11'd1;
               end else begin
                  rem_next = rem_sum;
               end
               if (y_adv > WIN_Y_W) begin
                  state_next = WON;
               end else if (state_reg == RUN) begin
                  if (jump_seen) begin
                     state_next = AIR;
                     bs_next    = 3'd1;
                     phase_next = 4'd0;
                     cnt_next   = '0;
                  end
               end else if (cnt_reg == STEP_LAST) begin
                  cnt_next = '0;
                  if (phase_reg == 4'd9) begin
                     bs_next    = 3'd0;
                     state_next = RUN;
                  end else begin
                     phase_next = phase_reg + 4'd1;
                     bs_next    = height_of(phase_reg + 4'd1);
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end

      // The tile under the ball has settled two clocks after the tick.
      if (tick_d2_reg && state_reg == RUN && bs_reg == 3'd0 && !bus.tile_solid) begin
         state_next = DEAD;
         fail_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         x_reg        <= 10'(X_INIT);
         y_reg        <= '0;
         rem_reg      <= '0;
         row_reg      <= '0;
         lane_reg     <= 3'(X_INIT / LANE_W);
         bs_reg       <= '0;
         phase_reg    <= '0;
         cnt_reg      <= '0;
         fail_reg     <= 1'b0;
         jump_req_reg <= 1'b0;
         tick_d1_reg  <= 1'b0;
         tick_d2_reg  <= 1'b0;
         left_s1_reg  <= 1'b0;
         left_s2_reg  <= 1'b0;
         right_s1_reg <= 1'b0;
         right_s2_reg <= 1'b0;
         jump_s1_reg  <= 1'b0;
         jump_s2_reg  <= 1'b0;
         jump_s3_reg  <= 1'b0;
      end else begin
         x_reg        <= x_next;
         y_reg        <= y_next;
         rem_reg      <= rem_next;
         row_reg      <= row_next;
         lane_reg     <= lane_next;
         bs_reg       <= bs_next;
         phase_reg    <= phase_next;
         cnt_reg      <= cnt_next;
         fail_reg     <= fail_next;
         jump_req_reg <= jump_req_next;
         tick_d1_reg  <= tick;
         tick_d2_reg  <= tick_d1_reg;
         left_s1_reg  <= btn_left;
         left_s2_reg  <= left_s1_reg;
         right_s1_reg <= btn_right;
         right_s2_reg <= right_s1_reg;
         jump_s1_reg  <= btn_jump;
         jump_s2_reg  <= jump_s1_reg;
         jump_s3_reg  <= jump_s2_reg;
      end
   end

   assign bus.x_ball     = x_reg;
   assign bus.y_ball     = y_reg;
   assign bus.q_row      = row_reg;
   assign bus.q_lane     = lane_reg;
   assign bus.ball_state = bs_reg;
   assign bus.fail       = fail_reg;

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: bench for ball_ctrl. A game-level model (position arithmetic,
// a jump height table indexed by airborne tick count, division for lane/row)
// predicts every output after each frame tick.
module tb_ball_ctrl;
   logic clk, clrn, tick, btn_left, btn_right, btn_jump;
   ball_if bus();

   ball_ctrl dut (
      .clk       (clk),
      .clrn      (clrn),
      .tick      (tick),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_jump  (btn_jump),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_RUN = 1, M_AIR = 2, M_DEAD = 3, M_WON = 4;
   int checks = 0;
   int errors = 0;
   int ntick  = 0;
   int m_mode, m_x, m_y, m_air, m_bs, m_fail;
   int arc [11] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_x = 200; m_y = 0; m_air = 0; m_bs = 0; m_fail = 0;
   endtask

   task automatic model_tick(input logic l, input logic r, input logic j, input logic s);
      case (m_mode)
         M_IDLE: if (j) m_mode = M_RUN;
         M_RUN, M_AIR: begin
            m_y += 4;
            if (l && !r) m_x = (m_x - 3 < 46) ? 46 : m_x - 3;
            if (r && !l) m_x = (m_x + 3 > 353) ? 353 : m_x + 3;
            if (m_y > 16000) m_mode = M_WON;
            else if (m_mode == M_RUN && j) begin
               m_mode = M_AIR; m_air = 0; m_bs = arc[0];
            end else if (m_mode == M_AIR) begin
               m_air++;
               m_bs = arc[m_air / 4];
               if (m_bs == 0) m_mode = M_RUN;
            end
         end
         default: ;
      endcase
      if (m_mode == M_RUN && m_bs == 0 && !s) begin
         m_mode = M_DEAD; m_fail = 1;
      end
   endtask

   task automatic check_all(input string tag);
      int row;
      row = (m_y / 80 > 2047) ? 2047 : m_y / 80;
      chk({tag, ".x_ball"},     32'(bus.x_ball),     m_x);
      chk({tag, ".y_ball"},     32'(bus.y_ball),     m_y);
      chk({tag, ".ball_state"}, 32'(bus.ball_state), m_bs);
      chk({tag, ".fail"},       32'(bus.fail),       m_fail);
      chk({tag, ".q_lane"},     32'(bus.q_lane),     m_x / 50);
      chk({tag, ".q_row"},      32'(bus.q_row),      row);
   endtask

   // One frame: buttons settle through the synchronizers, tick, then the
   // three-clock check pipeline drains before outputs are compared.
   task automatic do_tick(input logic l, input logic r, input logic j, input logic s);
      int fail_before;
      btn_left = l; btn_right = r; btn_jump = j; bus.tile_solid = s;
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      fail_before = m_fail;
      @(negedge clk);
      chk("fail_latency", 32'(bus.fail), fail_before);
      btn_jump = 1'b0;
      repeat (2) @(negedge clk);
      model_tick(l, r, j, s);
      ntick++;
      $display("tick %0d: l=%b r=%b j=%b solid=%b -> x=%0d y=%0d bs=%0d fail=%b lane=%0d row=%0d",
               ntick, l, r, j, s, bus.x_ball, bus.y_ball, bus.ball_state, bus.fail,
               bus.q_lane, bus.q_row);
      check_all("tick");
   endtask

   task automatic apply_reset();
      btn_left = 0; btn_right = 0; btn_jump = 0; tick = 0;
      @(negedge clk);
      #2 clrn = 1'b0;
      #1 model_reset();
      check_all("reset");
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      clrn = 1'b1; tick = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
      bus.tile_solid = 1'b1;
      model_reset();
      apply_reset();

      // Idle: nothing moves without a start press.
      for (int i = 0; i < 10; i++) do_tick(0, 0, 0, 0);

      // Start, then 20 running ticks on solid ground.
      do_tick(0, 0, 1, 1);
      for (int i = 0; i < 20; i++) do_tick(0, 0, 0, 1);
      chk("run20.y_ball", 32'(bus.y_ball), 80);
      chk("run20.q_row", 32'(bus.q_row), 1);

      // Jump over a gap; landing on a hole kills the run.
      do_tick(0, 0, 1, 0);
      for (int i = 0; i < 40; i++)
         do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      chk("land_on_hole.fail", 32'(bus.fail), 1);
      for (int i = 0; i < 3; i++) do_tick(1, 0, 1, 1);

      // Steering saturation.
      apply_reset();
      do_tick(0, 0, 1, 1);
      for (int i = 0; i < 100; i++) do_tick(0, 1, 0, 1);
      chk("right_sat.x_ball", 32'(bus.x_ball), 353);
      chk("right_sat.q_lane", 32'(bus.q_lane), 7);
      for (int i = 0; i < 10; i++) do_tick(1, 1, 0, 1);
      chk("both.x_ball", 32'(bus.x_ball), 353);
      for (int i = 0; i < 200; i++) do_tick(1, 0, 0, 1);
      chk("left_sat.x_ball", 32'(bus.x_ball), 46);
      chk("left_sat.q_lane", 32'(bus.q_lane), 0);

      // Random steering and jumps on solid ground.
      for (int i = 0; i < 150; i++)
         do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1);

      // Run to the finish line.
      for (int i = 0; i < 5000 && m_mode != M_WON; i++) do_tick(0, 0, 0, 1);
      chk("won_reached", 32'(m_mode), M_WON);
      for (int i = 0; i < 5; i++)
         do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
      chk("won.fail", 32'(bus.fail), 0);

      // Reset mid-jump at height 4.
      apply_reset();
      do_tick(0, 0, 1, 1);
      do_tick(0, 0, 0, 1);
      do_tick(0, 0, 1, 1);
      for (int i = 0; i < 60 && m_bs != 4; i++) do_tick(0, 0, 0, 1);
      chk("midair.ball_state", 32'(bus.ball_state), 4);
      apply_reset();
      for (int i = 0; i < 5; i++) do_tick(1, 0, 0, 0);
      chk("after_reset.y_ball", 32'(bus.y_ball), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
